seq_shift_unit: RTL and testbench

- Multi-cycle iterative shifter for the datapath.
- Takes a k-bit operand, a 2-bit shift op and a shift amount. Shifts the operand one bit position per clock until the amount is used up, then presents the result with a one-cycle done pulse.
- Uses the same 2-bit op encoding as the single-bit datapath shifter, extended to N-bit shifts under controller handshake.

---
 rtl/seq_shift_unit.sv | 145 ++++++++++++++
 tb/tb_seq_shift_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_unit.sv
// seq_shift_unit: iterative shifter, one bit position per clock.
// Optional LSL overflow flag output enabled by SEQ_SHIFT_OVF_EN.
module seq_shift_unit #(
    parameter int k  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [k-1:0]  in,
    input  logic [1:0]    shift,
    input  logic [AW-1:0] amount,
    output logic          busy,
    output logic          done,
`ifdef SEQ_SHIFT_OVF_EN
    output logic          ovf,
`endif
    output logic [k-1:0]  out
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_LSL  = 2'b01;
    localparam logic [1:0] OP_LSR  = 2'b10;
    localparam logic [1:0] OP_ASR  = 2'b11;

    state_t        state, state_n;
    logic [k-1:0]  work, work_n;
    logic [1:0]    op, op_n;
    logic [AW-1:0] cnt, cnt_n;
    logic [k-1:0]  out_q, out_n;
    logic [k-1:0]  step;
    logic          accept;

`ifdef SEQ_SHIFT_OVF_EN
    logic          acc, acc_n;
    logic          acc_step;
    logic          ovf_q, ovf_n;
`endif

    // One-bit shift of the working register according to the latched op
    always_comb begin
        step = work;
        unique case (op)
            OP_LSL:  step = {work[k-2:0], 1'b0};
            OP_LSR:  step = {1'b0, work[k-1:1]};
            OP_ASR:  step = {work[k-1], work[k-1:1]};
            default: step = work;
        endcase
    end

    assign accept = start && (state != S_SHIFT);

`ifdef SEQ_SHIFT_OVF_EN
    // Sticky record of ones pushed out of the MSB during a left shift
    assign acc_step = acc | ((op == OP_LSL) & work[k-1]);
`endif

    // Next-state and datapath loads; start is honoured in IDLE and DONE
    always_comb begin
        state_n = state;
        work_n  = work;
        op_n    = op;
        cnt_n   = cnt;
        out_n   = out_q;
`ifdef SEQ_SHIFT_OVF_EN
        acc_n   = acc;
        ovf_n   = ovf_q;
`endif
        unique case (state)
            S_SHIFT: begin
                work_n = step;
                cnt_n  = cnt - AW'(1);
`ifdef SEQ_SHIFT_OVF_EN
                acc_n  = acc_step;
`endif
                if (cnt == AW'(1)) begin
                    out_n   = step;
                    state_n = S_DONE;
`ifdef SEQ_SHIFT_OVF_EN
                    ovf_n   = acc_step;
`endif
                end
            end
            default: begin
                state_n = S_IDLE;
                if (accept) begin
                    work_n = in;
                    op_n   = shift;
                    cnt_n  = amount;
`ifdef SEQ_SHIFT_OVF_EN
                    acc_n  = 1'b0;
`endif
                    if (amount == '0 || shift == OP_PASS) begin
                        out_n   = in;
                        state_n = S_DONE;
`ifdef SEQ_SHIFT_OVF_EN
                        ovf_n   = 1'b0;
`endif
                    end else begin
                        state_n = S_SHIFT;
                    end
                end
            end
        endcase
    end

    // State and datapath registers, cleared by async reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            work  <= '0;
            op    <= OP_PASS;
            cnt   <= '0;
            out_q <= '0;
`ifdef SEQ_SHIFT_OVF_EN
            acc   <= 1'b0;
            ovf_q <= 1'b0;
`endif
        end else begin
            state <= state_n;
            work  <= work_n;
            op    <= op_n;
            cnt   <= cnt_n;
            out_q <= out_n;
`ifdef SEQ_SHIFT_OVF_EN
            acc   <= acc_n;
            ovf_q <= ovf_n;
`endif
        end
    end

    assign busy = (state == S_SHIFT);
    assign done = (state == S_DONE);
    assign out  = out_q;
`ifdef SEQ_SHIFT_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb_seq_shift_unit: directed vectors for seq_shift_unit.
// Optional ovf checks compiled in with SEQ_SHIFT_OVF_EN.
module tb_seq_shift_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] in;
    logic [1:0]  shift;
    logic [3:0]  amount;
    logic        busy;
    logic        done;
    logic [15:0] out;
`ifdef SEQ_SHIFT_OVF_EN
    logic        ovf;
`endif

    int n_cmp;
    int n_bad;

    seq_shift_unit #(.k(16), .AW(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .in      (in),
        .shift   (shift),
        .amount  (amount),
        .busy    (busy),
        .done    (done),
`ifdef SEQ_SHIFT_OVF_EN
        .ovf     (ovf),
`endif
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive one request and wait for done; check latency, busy
    // length, out hold during SHIFT, and the result.
    task automatic do_op(input string tag, input logic [15:0] d,
                         input logic [1:0] s, input logic [3:0] a,
                         input logic [15:0] exp, input int exp_lat);
        int lat;
        int nbusy;
        logic [15:0] prev;
        @(negedge clk);
        in     = d;
        shift  = s;
        amount = a;
        start  = 1'b1;
        prev   = out;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        nbusy = 0;
        while (!done && lat < 40) begin
            if (busy) begin
                nbusy++;
                if (nbusy == 1) chk({tag, "_hold"}, out, prev);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, nbusy, exp_lat - 1);
        chk({tag, "_out"}, out, exp);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        in      = '0;
        shift   = '0;
        amount  = '0;
        idle(2);
        chk("rst_out", out, 16'h0000);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
`ifdef SEQ_SHIFT_OVF_EN
        chk("rst_ovf", ovf, 1'b0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);

        do_op("lsl4", 16'h0001, 2'b01, 4'd4, 16'h0010, 5);
        idle(1);
        chk("done_pulse", done, 1'b0);
        chk("out_held", out, 16'h0010);
        idle(1);
        do_op("asr3", 16'h8000, 2'b11, 4'd3, 16'hF000, 4);
        idle(2);
        do_op("lsr15", 16'h8000, 2'b10, 4'd15, 16'h0001, 16);
        idle(2);
        do_op("pass7", 16'h1234, 2'b00, 4'd7, 16'h1234, 1);
        idle(2);
        do_op("lsl0", 16'hABCD, 2'b01, 4'd0, 16'hABCD, 1);
        idle(2);
        do_op("asr15", 16'h8421, 2'b11, 4'd15, 16'hFFFF, 16);
        idle(2);
        do_op("asr15p", 16'h7FFF, 2'b11, 4'd15, 16'h0000, 16);
        idle(2);
        do_op("lsl15", 16'h0003, 2'b01, 4'd15, 16'h8000, 16);
        idle(2);
        do_op("lsr4", 16'h00F0, 2'b10, 4'd4, 16'h000F, 5);
        do_op("b2b", 16'h0F00, 2'b01, 4'd1, 16'h1E00, 2);
        idle(2);

        // Second request while busy must be ignored
        @(negedge clk);
        in = 16'h0001; shift = 2'b01; amount = 4'd4; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        in = 16'hFFFF; shift = 2'b10; amount = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; in = 16'h5555; shift = 2'b00; amount = 4'd0;
        begin
            int w;
            w = 0;
            while (!done && w < 40) begin
                @(negedge clk);
                w++;
            end
            chk("ign_wait", w, 2);
        end
        chk("ign_out", out, 16'h0010);
        @(negedge clk);
        chk("ign_idle", done, 1'b0);
        idle(2);

        // Reset in the middle of a long shift
        @(negedge clk);
        in = 16'h00FF; shift = 2'b01; amount = 4'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        idle(3);
        chk("mid_busy", busy, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_out", out, 16'h0000);
        chk("mrst_done", done, 1'b0);
        chk("mrst_busy", busy, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        do_op("post", 16'h0101, 2'b10, 4'd8, 16'h0001, 9);
        idle(2);

`ifdef SEQ_SHIFT_OVF_EN
        do_op("ovf1", 16'h4001, 2'b01, 4'd2, 16'h0004, 3);
        chk("ovf1_flag", ovf, 1'b1);
        idle(2);
        chk("ovf1_hold", ovf, 1'b1);
        do_op("ovf0", 16'h0001, 2'b01, 4'd2, 16'h0004, 3);
        chk("ovf0_flag", ovf, 1'b0);
        idle(2);
        do_op("ovfasr", 16'hC000, 2'b11, 4'd2, 16'hF000, 3);
        chk("ovfasr_flag", ovf, 1'b0);
        idle(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
